// File: rtl/xbus_bridge_pkg.sv
// rtl/xbus_bridge_pkg.sv - shared types and constants for the xbus bridge
//   Holds the bridge FSM state encoding, bus field widths and the default
//   read data returned to the core when a transfer is aborted.
package xbus_bridge_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } xbus_state_e;

endpackage

// File: rtl/xbus_timeout_cnt.sv
// rtl/xbus_timeout_cnt.sv - transfer timeout counter with terminal-count flag
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : zero the count
//   en         : count this cycle (transfer outstanding)
//   tc         : this enabled cycle is the TIMEOUT-th one since clear
module xbus_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // The count including the current cycle reaches TIMEOUT here, so the
  // transfer gets at most TIMEOUT cycles before it is aborted.
  assign tc = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/xbus_bridge.sv
// rtl/xbus_bridge.sv - core data port to valid/ready system bus bridge
//   core_*   : single-cycle request from the execute stage, read data back
//   hold_o   : freezes the core pipeline while a transfer is outstanding
//   bus_*    : address phase (valid/ready) and read response (rvalid/rdata)
//   err_o    : one-cycle pulse when a hung transfer is aborted
module xbus_bridge
  import xbus_bridge_pkg::*;
#(
  parameter int                 TIMEOUT  = 255,
  parameter logic [DATA_W-1:0]  ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_data_i,
  input  logic              core_we_i,
  input  logic              core_req_i,
  output logic [DATA_W-1:0] core_data_o,
  output logic              hold_o,
  output logic              bus_valid_o,
  input  logic              bus_ready_i,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  output logic              bus_we_o,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              err_o
);

  xbus_state_e state, state_nxt;
  logic        tc;
  logic        abort;

  xbus_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == IDLE),
    .en    ((state == ADDR) || (state == RESP)),
    .tc    (tc)
  );

  // A completing handshake in the terminal cycle beats the timeout.
  assign abort = tc && (((state == ADDR) && !bus_ready_i) ||
                        ((state == RESP) && !bus_rvalid_i));

  // The IDLE term stalls the core in the same cycle it raises the request.
  assign hold_o = ((state == IDLE) && core_req_i) || (state == ADDR) || (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (core_req_i) state_nxt = ADDR;
      ADDR: begin
        if (bus_ready_i)  state_nxt = bus_we_o ? DONE : RESP;
        else if (tc)      state_nxt = DONE;
      end
      RESP: if (bus_rvalid_i || tc) state_nxt = DONE;
      // The core re-presents its request in DONE; it is consumed, not reissued.
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_valid_o <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_we_o    <= 1'b0;
      core_data_o <= '0;
      err_o       <= 1'b0;
    end else begin
      err_o <= abort;
      case (state)
        IDLE: begin
          if (core_req_i) begin
            bus_valid_o <= 1'b1;
            bus_addr_o  <= core_addr_i;
            bus_wdata_o <= core_data_i;
            bus_we_o    <= core_we_i;
          end
        end
        ADDR: begin
          if (bus_ready_i || tc) bus_valid_o <= 1'b0;
          if (abort && !bus_we_o) core_data_o <= ERR_DATA;
        end
        RESP: begin
          if (bus_rvalid_i)  core_data_o <= bus_rdata_i;
          else if (tc)       core_data_o <= ERR_DATA;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xbus_bridge.sv
// tb/tb_xbus_bridge.sv - scoreboard bench for xbus_bridge
module tb_xbus_bridge;

  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] core_addr_i = '0;
  logic [31:0] core_data_i = '0;
  logic        core_we_i = 1'b0;
  logic        core_req_i = 1'b0;
  logic [31:0] core_data_o;
  logic        hold_o;
  logic        bus_valid_o;
  logic        bus_ready_i = 1'b0;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_we_o;
  logic        bus_rvalid_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;
  logic        err_o;

  xbus_bridge #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .core_addr_i  (core_addr_i),
    .core_data_i  (core_data_i),
    .core_we_i    (core_we_i),
    .core_req_i   (core_req_i),
    .core_data_o  (core_data_o),
    .hold_o       (hold_o),
    .bus_valid_o  (bus_valid_o),
    .bus_ready_i  (bus_ready_i),
    .bus_addr_o   (bus_addr_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_we_o     (bus_we_o),
    .bus_rvalid_i (bus_rvalid_i),
    .bus_rdata_i  (bus_rdata_i),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] data;
    logic        err;
    int          hold;
    int          vcyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: outcome of a transfer from the slave's ready delay
  // (ADDR cycles before accept) and rvalid delay (RESP cycles before data).
  function automatic exp_t model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input int d_r, input int d_v);
    exp_t e;
    int   busy;
    logic ok;
    e.we = we; e.addr = addr; e.wdata = wdata;
    if (d_r >= TO) begin
      ok = 1'b0; busy = TO; e.vcyc = TO;
    end else begin
      e.vcyc = d_r + 1;
      if (we) begin
        ok = 1'b1; busy = d_r + 1;
      end else if (d_r + 1 + d_v < TO) begin
        ok = 1'b1; busy = d_r + d_v + 2;
      end else begin
        ok = 1'b0; busy = TO;
      end
    end
    e.err  = !ok;
    e.hold = busy + 1;
    e.data = we ? last_data : (ok ? rdata : ERR);
    return e;
  endfunction

  // Monitor: counts hold/valid cycles, checks the address phase fields and
  // compares the completion against the scoreboard head in DONE.
  int hold_cnt = 0;
  int vcnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_cnt = 0;
      vcnt = 0;
    end else begin
      if (hold_o) hold_cnt++;
      if (bus_valid_o) begin
        vcnt++;
        if (sb.size() > 0) begin
          chk("bus_addr", bus_addr_o, sb[0].addr);
          chk("bus_wdata", bus_wdata_o, sb[0].wdata);
          chk("bus_we", 32'(bus_we_o), 32'(sb[0].we));
        end
      end
      if (core_req_i && !hold_o) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got completion expected none");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("core_data", core_data_o, e.data);
          chk("err_pulse", 32'(err_o), 32'(e.err));
          chk("hold_cycles", 32'(hold_cnt), 32'(e.hold));
          chk("valid_cycles", 32'(vcnt), 32'(e.vcyc));
          chk("valid_done", 32'(bus_valid_o), 32'd0);
        end
        hold_cnt = 0;
        vcnt = 0;
      end else begin
        chk("err_quiet", 32'(err_o), 32'd0);
      end
    end
  end

  // Runs one transfer, acting as core and slave; returns in the IDLE cycle
  // after DONE with the request still driven so a next one can follow.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int d_r, input int d_v);
    exp_t e;
    int   aidx = 0;
    int   ridx = 0;
    bit   done = 0;
    e = model(we, addr, wdata, rdata, d_r, d_v);
    if (!we) last_data = e.data;
    sb.push_back(e);
    core_req_i = 1'b1; core_we_i = we; core_addr_i = addr; core_data_i = wdata;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk); #1;
      bus_ready_i = 1'b0;
      bus_rvalid_i = 1'b0;
      if (!hold_o) begin
        done = 1;
      end else if (bus_valid_o) begin
        bus_ready_i = (aidx == d_r);
        aidx++;
        bus_rvalid_i = 1'($urandom_range(0, 1));
        bus_rdata_i = $urandom;
      end else begin
        bus_rvalid_i = (ridx == d_v);
        bus_rdata_i = (ridx == d_v) ? rdata : $urandom;
        ridx++;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL txn_budget: got no completion expected DONE within 40 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    core_req_i = 1'b0;
    bus_ready_i = 1'b0;
    bus_rvalid_i = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_valid", 32'(bus_valid_o), 32'd0);
    chk("rst_hold", 32'(hold_o), 32'd0);
    chk("rst_addr", bus_addr_o, 32'd0);
    chk("rst_data", core_data_o, 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    @(posedge clk); #1;

    // Directed cases
    do_txn(1'b0, 32'h0000_1000, 32'h0, 32'h1234_5678, 0, 0);
    idle(2);
    do_txn(1'b1, 32'h8000_0010, 32'hA5A5_A5A5, 32'h0, 4, 0);
    idle(1);
    do_txn(1'b0, 32'h0000_2000, 32'h0, 32'h5555_0000, 100, 0);
    idle(1);
    do_txn(1'b0, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 0, TO - 2);
    idle(1);
    do_txn(1'b0, 32'h0000_3004, 32'h0, 32'h0BAD_0BAD, 0, TO - 1);
    idle(1);
    do_txn(1'b1, 32'h0000_4000, 32'h1111_2222, 32'h0, TO - 1, 0);
    idle(1);
    do_txn(1'b0, 32'h0000_5000, 32'h0, 32'hAAAA_0001, 0, 0);
    do_txn(1'b0, 32'h0000_5004, 32'h0, 32'hAAAA_0002, 1, 1);
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      int d_r, d_v;
      d_r = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 2) : $urandom_range(0, 3);
      d_v = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 3, TO) : $urandom_range(0, 3);
      do_txn(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, d_r, d_v);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(1);

    // Reset while waiting for read data
    core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h0000_6000;
    @(posedge clk); #1;
    bus_ready_i = 1'b1;
    @(posedge clk); #1;
    bus_ready_i = 1'b0;
    #2 rst_n = 1'b0;
    core_req_i = 1'b0;
    #1;
    chk("rstmid_valid", 32'(bus_valid_o), 32'd0);
    chk("rstmid_hold", 32'(hold_o), 32'd0);
    chk("rstmid_data", core_data_o, 32'd0);
    chk("rstmid_addr", bus_addr_o, 32'd0);
    chk("rstmid_err", 32'(err_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h7777_7777;
    @(posedge clk); #1;
    bus_rvalid_i = 1'b0;
    @(posedge clk); #1;
    chk("late_rvalid_data", core_data_o, 32'd0);
    chk("late_rvalid_hold", 32'(hold_o), 32'd0);
    chk("late_rvalid_valid", 32'(bus_valid_o), 32'd0);
    chk("late_rvalid_err", 32'(err_o), 32'd0);
    last_data = '0;

    // Transfers still work after the reset
    do_txn(1'b0, 32'h0000_7000, 32'h0, 32'h0F0F_0F0F, 0, 2);
    idle(2);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xbus_bridge.md
Name: xbus_bridge

Overview:
- Sits directly downstream of the core's execute-stage data port: consumes the core's single-cycle memory request (address, write data, write enable, request) and drives the system data bus.
- Converts each request into a valid/ready address phase plus a read-response phase.
- Asserts hold back into the core's hold input so the pipeline freezes while a transfer is outstanding.
- Aborts hung transfers with a timeout.

Parameters:
- TIMEOUT, 255, maximum cycles in ADDR+RESP before abort; counter width is $clog2(TIMEOUT+1).
- ERR_DATA, 32'hDEAD_BEEF, read data returned to the core on timeout.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- core_addr_i  input  32  request address from core execute stage
- core_data_i  input  32  write data from core
- core_we_i  input  1  1=write, 0=read
- core_req_i  input  1  request valid from core
- core_data_o  output  32  read data to core
- hold_o  output  1  to core's xbus hold input
- bus_valid_o  output  1  address phase valid
- bus_ready_i  input  1  slave accepts address phase
- bus_addr_o  output  32  latched address
- bus_wdata_o  output  32  latched write data
- bus_we_o  output  1  latched write enable
- bus_rvalid_i  input  1  read data valid
- bus_rdata_i  input  32  read data
- err_o  output  1  one-cycle pulse on timeout abort

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values:
  - state=IDLE.
  - bus_valid_o=0, bus_addr_o=0, bus_wdata_o=0, bus_we_o=0.
  - core_data_o=0, err_o=0, timeout counter=0.
  - hold_o=0 unless core_req_i=1 (combinational term, see below).
- States: IDLE, ADDR, RESP, DONE.
- IDLE:
  - On core_req_i=1: latch addr/wdata/we into the bus_* registers, clear the counter, go to ADDR.
  - If core_req_i=0: stay.
- ADDR:
  - bus_valid_o=1; counter increments each cycle.
  - bus_ready_i=1 and bus_we_o=1 -> DONE (write complete on accept; no response phase).
  - bus_ready_i=1 and bus_we_o=0 -> RESP.
  - bus_valid_o and the bus_* fields stay stable until accepted.
- RESP:
  - bus_valid_o=0; counter continues.
  - bus_rvalid_i=1 -> latch bus_rdata_i into core_data_o, go to DONE.
  - A bus_rvalid_i outside RESP is ignored.
- Timeout:
  - In ADDR or RESP, when counter==TIMEOUT and the completing handshake is absent that cycle, go to DONE.
  - On entry to DONE: core_data_o=ERR_DATA for reads (unchanged for writes), err_o=1 for exactly that DONE cycle, bus_valid_o drops.
  - A handshake in the same cycle as the timeout wins: normal completion, no error.
- DONE:
  - hold_o=0 so the pipeline advances.
  - The core re-presents the same request this cycle; the bridge consumes it without reissue.
  - core_data_o is held valid.
  - Next state is IDLE unconditionally.
- hold_o = (IDLE & core_req_i) | ADDR | RESP.
  - The combinational IDLE term is required: the core must stall in the same cycle it raises the request.
- Minimum latency:
  - Write with bus_ready_i=1 in the first ADDR cycle: hold high 2 cycles (IDLE-req, ADDR), DONE on the 3rd.
  - Read with 0-wait ready and rvalid: hold high 3 cycles.
- Back-to-back: a request arriving in the cycle after DONE (state IDLE) starts a new transfer immediately.
- Reset mid-transfer: immediate return to IDLE, bus_valid_o drops asynchronously, no err_o pulse; any late bus_rvalid_i is ignored.
- core_data_o holds its last value outside DONE.

Decomposition:
- Shared package holds:
  - State encoding: IDLE=2'd0, ADDR=2'd1, RESP=2'd2, DONE=2'd3.
  - ERR_DATA default.
  - The bus transaction field widths (32-bit addr/data).
- Natural sub-module: xbus_timeout_cnt (clear, enable, terminal-count flag, param TIMEOUT).
- Everything else stays in one FSM module.

Test Plan:
- Read, slave ready=1 in first ADDR cycle, rvalid with 0x1234_5678 next cycle:
  - core_data_o=0x1234_5678 in DONE; hold_o high exactly 3 cycles; single bus_valid_o cycle.
- Write addr 0x8000_0010 data 0xA5A5_A5A5, ready held low 4 cycles then high:
  - bus fields stable across all 5 valid cycles; hold_o 6 cycles; no response wait; err_o=0.
- Read with slave never asserting ready, TIMEOUT=8:
  - DONE reached after 8 ADDR cycles; core_data_o=0xDEAD_BEEF; err_o one-cycle pulse; bus_valid_o=0.
- Read with rvalid on the exact timeout cycle:
  - normal data returned, err_o=0.
- Two reads back-to-back (request re-presented in DONE, new address the following cycle):
  - first consumed once only (single bus_valid_o pulse set); second issues from IDLE the next cycle.
- Assert rst_n=0 during RESP, then pulse bus_rvalid_i after release:
  - state IDLE, outputs at reset values, late rvalid ignored, core_data_o=0.
